// File: rtl/tx8_serializer_pkg.sv
// Shared definitions for the 8-bit parallel-to-serial transmitter.
//   tx_state_t : FSM state encoding (IDLE=1'b0, SHIFT=1'b1)
//   head_bit() : bit of a byte that goes out on the wire first for a given order
package tx8_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int unsigned FRAME_BITS = 8;

    // Bit currently at the "output end" of the shift register.
    function automatic logic head_bit(input logic [7:0] v, input bit lsb_first);
        return lsb_first ? v[0] : v[7];
    endfunction

endpackage

// File: rtl/tx8_serializer_period.sv
// bit_period_cnt: free-running bit-period counter with synchronous clear.
//   clk   : clock, rising edge
//   res   : asynchronous active-low reset
//   clear : forces the count back to 0 on the next edge
//   limit : terminal count (BIT_CYCLES-1)
//   tick  : high while count == limit
module bit_period_cnt (
    input  logic       clk,
    input  logic       res,
    input  logic       clear,
    input  logic [7:0] limit,
    output logic       tick
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge res) begin
        if (!res)       count <= 8'd0;
        else if (clear) count <= 8'd0;
        else            count <= count + 8'd1;
    end

    assign tick = (count == limit);

endmodule

// File: rtl/tx8_serializer.sv
// tx8_serializer: accepts one byte over a valid/ready handshake and shifts it
// out one bit per BIT_CYCLES clocks, framed by Ser_Frame.
//   clk       : clock, rising edge
//   res       : asynchronous active-low reset (aborts any frame in flight)
//   Tx_Data   : byte to send, sampled only on handshake
//   Tx_Valid  : source offers Tx_Data
//   Tx_Ready  : high only in IDLE (combinational from state)
//   Ser_Out   : serial data, registered
//   Ser_Frame : high while the 8 data bits are on Ser_Out, registered
//   Tx_Done   : one-cycle pulse after the last bit period, registered
module tx8_serializer
    import tx8_serializer_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1,
    parameter bit          LSB_FIRST  = 1
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Valid,
    output logic       Tx_Ready,
    output logic       Ser_Out,
    output logic       Ser_Frame,
    output logic       Tx_Done
);

    localparam logic [7:0] PERIOD_LIMIT = 8'(BIT_CYCLES - 1);

    tx_state_t  state;
    logic [7:0] sreg;
    logic [7:0] sreg_nxt;
    logic [2:0] bit_cnt;
    logic       tick;
    logic       period_clr;

    assign Tx_Ready = (state == IDLE);

    // Held at zero while idle so the first bit period starts counting from 0
    // right after the handshake edge; restarted at every bit boundary.
    assign period_clr = (state != SHIFT) | tick;

    bit_period_cnt u_period (
        .clk   (clk),
        .res   (res),
        .clear (period_clr),
        .limit (PERIOD_LIMIT),
        .tick  (tick)
    );

    // Move the next bit to the output end of the register.
    assign sreg_nxt = LSB_FIRST ? {1'b0, sreg[7:1]} : {sreg[6:0], 1'b0};

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            sreg      <= 8'd0;
            bit_cnt   <= 3'd0;
            Ser_Out   <= 1'b0;
            Ser_Frame <= 1'b0;
            Tx_Done   <= 1'b0;
        end else begin
            Tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Tx_Valid) begin
                        sreg      <= Tx_Data;
                        Ser_Out   <= head_bit(Tx_Data, LSB_FIRST);
                        Ser_Frame <= 1'b1;
                        bit_cnt   <= 3'd0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (bit_cnt != 3'd7) begin
                            sreg    <= sreg_nxt;
                            Ser_Out <= head_bit(sreg_nxt, LSB_FIRST);
                            bit_cnt <= bit_cnt + 3'd1;
                        end else begin
                            state     <= IDLE;
                            Ser_Out   <= 1'b0;
                            Ser_Frame <= 1'b0;
                            Tx_Done   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx8_serializer.sv
module tb_tx8_serializer;

    localparam int B0 = 1;
    localparam int B1 = 3;

    logic       clk = 1'b0;
    logic       res;
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic       r0, o0, f0, dn0;
    logic       r1, o1, f1, dn1;

    always #5 clk = ~clk;

    tx8_serializer #(.BIT_CYCLES(B0), .LSB_FIRST(1)) u0 (
        .clk(clk), .res(res), .Tx_Data(d0), .Tx_Valid(v0),
        .Tx_Ready(r0), .Ser_Out(o0), .Ser_Frame(f0), .Tx_Done(dn0));

    tx8_serializer #(.BIT_CYCLES(B1), .LSB_FIRST(0)) u1 (
        .clk(clk), .res(res), .Tx_Data(d1), .Tx_Valid(v1),
        .Tx_Ready(r1), .Ser_Out(o1), .Ser_Frame(f1), .Tx_Done(dn1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic g_out(input int d);   return d ? o1 : o0;   endfunction
    function automatic logic g_frame(input int d); return d ? f1 : f0;   endfunction
    function automatic logic g_done(input int d);  return d ? dn1 : dn0; endfunction
    function automatic logic g_ready(input int d); return d ? r1 : r0;   endfunction
    function automatic int   bcyc(input int d);    return d ? B1 : B0;   endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] data);
        if (d == 0) begin v0 = v; d0 = data; end
        else        begin v1 = v; d1 = data; end
    endtask

    // Reference model: "cycles since handshake" per DUT; the bit on the wire
    // is simply the byte indexed by elapsed time divided by the bit period.
    bit         m_busy[2];
    int         m_t[2];
    logic [7:0] m_byte[2];
    bit         m_done[2];
    bit         chk_en = 1'b0;

    always @(posedge clk or negedge res) begin
        if (!res) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 1'b0; m_t[d] = 0; m_done[d] = 1'b0; m_byte[d] = 8'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_done[d] = 1'b0;
                if (!m_busy[d]) begin
                    if ((d ? v1 : v0) === 1'b1) begin
                        m_busy[d] = 1'b1;
                        m_t[d]    = 0;
                        m_byte[d] = d ? d1 : d0;
                    end
                end else begin
                    m_t[d]++;
                    if (m_t[d] == 8 * bcyc(d)) begin
                        m_busy[d] = 1'b0;
                        m_done[d] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic m_out(input int d);
        int idx;
        if (!m_busy[d]) return 1'b0;
        idx = m_t[d] / bcyc(d);
        return (d == 0) ? m_byte[d][idx] : m_byte[d][7 - idx];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model d%0d ready t=%0t", d, $time), g_ready(d), !m_busy[d]);
                chk($sformatf("model d%0d frame t=%0t", d, $time), g_frame(d), m_busy[d]);
                chk($sformatf("model d%0d out t=%0t", d, $time), g_out(d), m_out(d));
                chk($sformatf("model d%0d done t=%0t", d, $time), g_done(d), m_done[d]);
            end
        end
    end

    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while (!g_ready(d) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("d%0d idle wait", d), g_ready(d), 1'b1);
    endtask

    // Called just after the handshake edge; returns at the Tx_Done negedge.
    // seq[7] is the first bit seen on the wire.
    task automatic capture(input int d, output logic [7:0] seq);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seq[7-k] = g_out(d);
            chk($sformatf("d%0d frame bit%0d", d, k), g_frame(d), 1'b1);
            chk($sformatf("d%0d ready busy bit%0d", d, k), g_ready(d), 1'b0);
            repeat (bcyc(d) - 1) @(negedge clk);
        end
        @(negedge clk);
        chk($sformatf("d%0d done after 8 periods", d), g_done(d), 1'b1);
        chk($sformatf("d%0d frame low at done", d), g_frame(d), 1'b0);
        chk($sformatf("d%0d ready at done", d), g_ready(d), 1'b1);
    endtask

    task automatic send(input int d, input logic [7:0] data, input bit hold,
                        input logic [7:0] alt, output logic [7:0] seq);
        wait_idle(d);
        drive(d, 1'b1, data);
        @(posedge clk);
        #1;
        if (hold) drive(d, 1'b1, alt);
        else      drive(d, 1'b0, data);
        capture(d, seq);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_lsb;  // expected wire order, LSB-first DUT
        logic [7:0] seq_msb;  // expected wire order, MSB-first DUT
    } vec_t;

    vec_t vecs[7];
    logic [7:0] seq;

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[1] = '{8'h81, 8'h81, 8'h81};
        vecs[2] = '{8'h0F, 8'hF0, 8'h0F};
        vecs[3] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[4] = '{8'h01, 8'h80, 8'h01};
        vecs[5] = '{8'h12, 8'h48, 8'h12};
        vecs[6] = '{8'hC8, 8'h13, 8'hC8};

        res = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset ready", d), g_ready(d), 1'b1);
            chk($sformatf("d%0d reset out", d), g_out(d), 1'b0);
            chk($sformatf("d%0d reset frame", d), g_frame(d), 1'b0);
            chk($sformatf("d%0d reset done", d), g_done(d), 1'b0);
        end
        repeat (2) @(negedge clk);
        res = 1'b1;
        chk_en = 1'b1;

        // Table of single frames on both bit orders / bit periods.
        for (int i = 0; i < 7; i++) begin
            send(0, vecs[i].data, 1'b0, 8'h00, seq);
            chk($sformatf("vec%0d lsb seq", i), seq, vecs[i].seq_lsb);
            send(1, vecs[i].data, 1'b0, 8'h00, seq);
            chk($sformatf("vec%0d msb seq", i), seq, vecs[i].seq_msb);
        end

        // Busy rejection: Tx_Valid held, Tx_Data changed mid-frame.
        send(0, 8'h0F, 1'b1, 8'hF0, seq);
        drive(0, 1'b0, 8'hF0);
        chk("busy lsb seq", seq, 8'hF0);
        send(1, 8'h0F, 1'b1, 8'hF0, seq);
        drive(1, 1'b0, 8'hF0);
        chk("busy msb seq", seq, 8'h0F);

        // Back-to-back: second handshake lands in the Tx_Done cycle.
        for (int d = 0; d < 2; d++) begin
            send(d, 8'h3C, 1'b1, 8'hC3, seq);
            @(posedge clk);
            #1;
            drive(d, 1'b0, 8'h00);
            capture(d, seq);
            chk($sformatf("d%0d b2b second seq", d), seq, 8'hC3);
        end

        // Mid-frame reset during bit 4 of 8'hFF, then 8'h01.
        for (int d = 0; d < 2; d++) begin
            wait_idle(d);
            drive(d, 1'b1, 8'hFF);
            @(posedge clk);
            #1;
            drive(d, 1'b0, 8'h00);
            repeat (4 * bcyc(d) + 1) @(negedge clk);
            chk($sformatf("d%0d bit4 out", d), g_out(d), 1'b1);
            #2;
            res = 1'b0;
            #1;
            chk($sformatf("d%0d async rst out", d), g_out(d), 1'b0);
            chk($sformatf("d%0d async rst frame", d), g_frame(d), 1'b0);
            chk($sformatf("d%0d async rst done", d), g_done(d), 1'b0);
            chk($sformatf("d%0d async rst ready", d), g_ready(d), 1'b1);
            @(negedge clk);
            res = 1'b1;
            for (int k = 0; k < 8 * bcyc(d); k++) begin
                @(negedge clk);
                chk($sformatf("d%0d no done after abort", d), g_done(d), 1'b0);
            end
            send(d, 8'h01, 1'b0, 8'h00, seq);
            chk($sformatf("d%0d post-reset seq", d), seq, d ? 8'h01 : 8'h80);
        end

        // Random traffic on both DUTs, checked cycle by cycle by the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            v0 = ($urandom_range(0, 3) == 0);
            d0 = 8'($urandom);
            v1 = ($urandom_range(0, 2) == 0);
            d1 = 8'($urandom);
        end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        repeat (40) @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
